// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [4:0]  ITER_LAST = 5'd31;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the unsigned datapath: MSB-first shift-add multiply or
// restoring divide step (acc = {remainder, quotient}) selected by is_div.
module mdu_iter_step
  import mdu_pkg::*;
(
  input  logic        is_div,
  input  logic        bit_in,
  input  logic [31:0] operand,
  input  logic [63:0] acc_i,
  output logic [63:0] acc_o
);

  logic [32:0] rem_sh;
  logic [32:0] trial;

  always_comb begin
    rem_sh = {acc_i[63:32], bit_in};
    trial  = rem_sh - {1'b0, operand};
    acc_o  = {acc_i[62:0], 1'b0} + (bit_in ? {32'd0, operand} : 64'd0);
    if (is_div) begin
      // remainder stays below the divisor, so rem_sh[32] is zero on restore
      acc_o = trial[32] ? {rem_sh[31:0], acc_i[30:0], 1'b0}
                        : {trial[31:0],  acc_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer with pipeline hold.
// MDU_FAST_MUL_EN: multiplies use a single-cycle product in PREP.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// PREP  | magnitudes, result signs, special cases, counter load
// CALC  | one shift-add / restoring-divide iteration per cycle
// DONE  | sign-correct, select half, pulse done, register result
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  flush,
  output logic                  busy,
  output logic                  hold_pipeline,
  output logic                  done,
  output logic [data_width-1:0] result
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  iter_cnt_q, iter_cnt_d;
  logic        quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
  logic [31:0] result_q, result_d;

  logic        is_div, a_signed, b_signed, a_neg, b_neg;
  logic        div_by_zero, div_ovf;
  logic [31:0] a_mag, b_mag, quot_fix, rem_fix, final_res;
  logic [63:0] prod_fix, step_acc;

  assign is_div      = op_q[2];
  assign a_signed    = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign b_signed    = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign a_neg       = a_signed && a_q[31];
  assign b_neg       = b_signed && b_q[31];
  assign a_mag       = mag32(a_q, a_signed);
  assign b_mag       = mag32(b_q, b_signed);
  assign div_by_zero = is_div && (b_q == 32'd0);
  assign div_ovf     = is_div && !op_q[0] && (a_q == INT_MIN) && (b_q == DIV0_QUOT);

  mdu_iter_step u_step (
    .is_div  (is_div),
    .bit_in  (is_div ? a_q[iter_cnt_q] : b_q[iter_cnt_q]),
    .operand (is_div ? b_q : a_q),
    .acc_i   (acc_q),
    .acc_o   (step_acc)
  );

  always_comb begin
    prod_fix = quot_neg_q ? (~acc_q + 64'd1) : acc_q;
    quot_fix = quot_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    unique case (op_q)
      OP_MUL:                        final_res = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[63:32];
      OP_DIV, OP_DIVU:               final_res = quot_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    iter_cnt_d = iter_cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = PREP;
          op_d    = mdu_op_e'(op);
          a_d     = operand_A;
          b_d     = operand_B;
        end
      end
      PREP: begin
        acc_d      = '0;
        iter_cnt_d = ITER_LAST;
        quot_neg_d = a_neg ^ b_neg;
        rem_neg_d  = a_neg;
        a_d        = a_mag;
        b_d        = b_mag;
        state_d    = CALC;
        // special cases park the final {rem, quot} in acc with no sign fix
        if (div_by_zero) begin
          acc_d      = {a_q, DIV0_QUOT};
          quot_neg_d = 1'b0;
          rem_neg_d  = 1'b0;
          state_d    = DONE;
        end else if (div_ovf) begin
          acc_d      = {32'd0, INT_MIN};
          quot_neg_d = 1'b0;
          rem_neg_d  = 1'b0;
          state_d    = DONE;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!is_div) begin
          acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
          state_d = DONE;
        end
`else
`endif
      end
      CALC: begin
        acc_d = step_acc;
        if (iter_cnt_q == 5'd0) state_d = DONE;
        else                    iter_cnt_d = iter_cnt_q - 5'd1;
      end
      DONE: begin
        state_d  = IDLE;
        result_d = final_res;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      iter_cnt_q <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      iter_cnt_q <= iter_cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign hold_pipeline = ((state_q == IDLE) && start && !flush) || (state_q == PREP) || (state_q == CALC);
  assign done          = (state_q == DONE) && !flush;
  assign result        = done ? final_res : result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed ops, special cases, flush, reset.
module tb_mdu_sequencer;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] operand_A = '0;
  logic [31:0] operand_B = '0;
  logic        busy, hold_pipeline, done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  mdu_sequencer #(.data_width(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .op            (op),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .flush         (flush),
    .busy          (busy),
    .hold_pipeline (hold_pipeline),
    .done          (done),
    .result        (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one op starting at the next cycle (cycle 0) and waits for done.
  // With stray set, an ignored start with different operands is raised mid-run.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag,
                        input bit stray);
    int          lat;
    bit          seen;
    bit          hold_ok;
    logic [31:0] want;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1; op = o; operand_A = a; operand_B = b;
    @(negedge clk);
    chk({tag, "_hold_c0"}, {31'd0, hold_pipeline}, 32'd1);
    chk({tag, "_done_c0"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; seen = 1'b0; hold_ok = 1'b1;
    while (!seen && lat < 80) begin
      @(negedge clk);
      if (stray) begin
        start = (lat == 5);
        op = MUL;
        operand_A = ~a;
        operand_B = 32'd3;
      end
      if (done) seen = 1'b1;
      else begin
        if (!hold_pipeline) hold_ok = 1'b0;
        lat++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_hold_until_done"}, {31'd0, hold_ok}, 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_hold_at_done"}, {31'd0, hold_pipeline}, 32'd0);
      want = exp_q.pop_front();
      chk({tag, "_result"}, result, want);
      last_res = want;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hold", {31'd0, hold_pipeline}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    run_op(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3", 1'b1);
    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_ones", 1'b0);
    run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_ones", 1'b0);
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_ones", 1'b0);
    run_op(DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT, "div_m7_2", 1'b1);
    run_op(REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT, "rem_m7_2", 1'b0);
    run_op(DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2", 1'b0);
    run_op(REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         DIV_LAT, "rem_7_m2", 1'b0);
    run_op(DIVU,   32'd100,      32'd7,        32'd14,        DIV_LAT, "divu_100_7", 1'b0);
    run_op(REMU,   32'd100,      32'd7,        32'd2,         DIV_LAT, "remu_100_7", 1'b0);
    run_op(DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, SPC_LAT, "divu_by0", 1'b0);
    run_op(REMU,   32'd5,        32'd0,        32'd5,         SPC_LAT, "remu_by0", 1'b0);
    run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        SPC_LAT, "rem_ovf", 1'b0);
    run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div_ovf", 1'b0);

    // flush at cycle 10 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = DIV; operand_A = 32'd100; operand_B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_c10_busy", {31'd0, busy}, 32'd1);
    chk("flush_c10_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_c11_busy", {31'd0, busy}, 32'd0);
    chk("flush_c11_hold", {31'd0, hold_pipeline}, 32'd0);
    chk("flush_c11_done", {31'd0, done}, 32'd0);
    chk("flush_c11_result", result, last_res);
    run_op(DIV, 32'd100, 32'd3, 32'd33, DIV_LAT, "div_after_flush", 1'b0);

    // flush together with start in IDLE drops the request
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = DIVU; operand_A = 32'd9; operand_B = 32'd2;
    @(negedge clk);
    chk("flush_start_hold", {31'd0, hold_pipeline}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // reset at cycle 20 of a DIVU
    @(posedge clk); #1;
    start = 1'b1; op = DIVU; operand_A = 32'd1000; operand_B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hold", {31'd0, hold_pipeline}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    last_res = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(MUL, 32'd6, 32'd7, 32'd42, MUL_LAT, "mul_6_7", 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for RV32M multiply/divide instructions in the execute stage, beside the single-cycle ALU. It accepts one M-type operation at a time, runs an iterative shift-add multiply or restoring divide over 32 iterations, and stalls the pipeline through `hold_pipeline` until the result is ready. Results are written back through the same execute-stage result mux as `ALU_result`.

## Interface
Parameters:
- `data_width`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request for a new operation. Sampled only in IDLE.
- `op`  in  3: funct3 code. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_A`  in  32: rs1 value, captured when `start` is accepted.
- `operand_B`  in  32: rs2 value, captured when `start` is accepted.
- `flush`  in  1: abort the operation in flight (branch or JALR redirect).
- `busy`  out  1: high in any state other than IDLE.
- `hold_pipeline`  out  1: stall request to the hazard unit.
- `done`  out  1: single-cycle pulse; `result` is valid in this cycle.
- `result`  out  32: result of the operation; holds its value until the next `done`.

## Operation
- States: IDLE, PREP, CALC, DONE.
- IDLE, `start` high: latch `op`, A and B, go to PREP. `hold_pipeline` rises combinationally in the same cycle as `start`.
- PREP, one cycle:
  - Sign handling: MULH takes signed×signed, MULHSU signed×unsigned. DIV and REM use absolute values and record the result sign.
  - Result sign: quotient negative when sign(A) XOR sign(B); remainder takes the sign of A.
  - Clear the 64-bit accumulator and set `iter_cnt` to 31.
  - Special cases go straight to DONE and skip CALC:
    - Divide by zero (B=0): quotient 0xFFFFFFFF; remainder = A.
    - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): quotient 0x80000000; remainder 0.
- CALC, one iteration per cycle:
  - Multiply: shift-add on the 64-bit product.
  - Divide: restoring step (shift remainder left, trial subtract, set quotient bit).
  - `iter_cnt` decrements each cycle. After the iteration with `iter_cnt`=0, go to DONE.
- DONE, one cycle:
  - Apply sign correction and select the output half: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register `result`, pulse `done`, return to IDLE.
- `flush` in PREP, CALC or DONE: go to IDLE on the next edge. No `done` pulse, `result` unchanged, `hold_pipeline` low from the next cycle.
- `flush` and `start` together in IDLE: `flush` wins and the request is dropped.
- `start` in any state other than IDLE: ignored.
- `hold_pipeline` = (IDLE && `start` && !`flush`) || PREP || CALC. It is low in DONE so the instruction advances in the same cycle as `done`.

## Timing
- Reset values: state IDLE, `busy` 0, `hold_pipeline` 0, `done` 0, `result` 0, `iter_cnt` 0, accumulators 0.
- Normal latency: `start` accepted at cycle 0, PREP at 1, CALC at 2–33, DONE with `done` at 34.
- Special-case latency: `done` at cycle 2.
- Back-to-back: a new `start` is accepted in the cycle after DONE, not during DONE.
- Reset asserted mid-operation: immediate return to IDLE; all outputs go to their reset values.

## Configuration
- `MDU_FAST_MUL_EN` defined: the four multiply ops bypass CALC. The 64-bit product is computed with a single `*` in PREP and DONE follows directly, so `done` comes at cycle 2. Divide is unchanged.
- Not defined: all ops use the iterative path with the latencies above.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_e`, enum of the eight funct3 codes.
  - `mdu_state_e`, enum IDLE/PREP/CALC/DONE.
  - Constants `DIV0_QUOT`=32'hFFFF_FFFF, `INT_MIN`=32'h8000_0000, `ITER_LAST`=5'd31.
- Sub-module `mdu_iter_step`: combinational single-iteration datapath (shift-add step or restoring-divide step) selected by an `is_div` input. The FSM, counter and sign logic stay in `mdu_sequencer`.

## Test plan
- MUL, A=7, B=-3 → `done` at cycle 34, `result`=0xFFFFFFEB; `hold_pipeline` high for cycles 0–33.
- MULHU, A=B=0xFFFFFFFF → `result`=0xFFFFFFFE. MULH with the same operands → `result`=0.
- DIV, A=-7, B=2 → `result`=0xFFFFFFFD. REM with the same operands → `result`=0xFFFFFFFF.
- DIVU with B=0 and A=5 → `result`=0xFFFFFFFF at cycle 2. REM with A=0x80000000, B=-1 → `result`=0 at cycle 2.
- DIV started, `flush` at cycle 10 → IDLE at cycle 11, no `done`, `result` keeps its prior value. A `start` at cycle 12 runs normally.
- `rst_n` pulled low at cycle 20 of a DIVU → all outputs 0 immediately. With `MDU_FAST_MUL_EN` defined, MUL 6×7 → `done` at cycle 2 with `result`=42.
